serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_ctrl_adder_slice.sv | 42 ++++
 rtl/serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  // Controller states: waiting, stepping the slice, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_adder_slice.sv
// One-bit full-adder slice built from two half adders and a carry OR.
// Purely combinational; the carry flop lives in the controller.

// Single half adder cell.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// Full-adder slice: HA1 forms propagate/generate, HA2 folds in the carry.
module adder_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;
  logic w_g1;
  logic w_g2;

  half_adder u_ha1 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_p),
    .o_c (w_g1)
  );

  half_adder u_ha2 (
    .i_a (w_p),
    .i_b (i_c),
    .o_s (o_s),
    .o_c (w_g2)
  );

  assign o_c = w_g1 | w_g2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures a/b on start, steps one adder slice
// per clock LSB first, and presents sum/carry with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into A-B (B inverted at capture, carry flop preset to 1).
//
// Handshake: start is sampled only in IDLE; an accepted start raises busy the
// next cycle; done pulses for exactly one cycle with sum/carry already valid;
// start seen in RUN or DONE is dropped, never queued.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output sa_state_t        o_state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_c_q;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_c_init;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1: invert B at capture and preset the carry.
  assign w_b_cap  = sub ? ~b : b;
  assign w_c_init = sub;
`else
  assign w_b_cap  = b;
  assign w_c_init = 1'b0;
`endif

  adder_slice u_slice (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_c_q),
    .o_s (w_s),
    .o_c (w_cout)
  );

  // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH steps.
  assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (r_cnt == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial stepping, and result load on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_c_q    <= 1'b0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_cap;
            r_sum_sh <= '0;
            r_c_q    <= w_c_init;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_c_q    <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          // Final step: the result is visible in the same cycle done rises.
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign sum         = r_sum;
  assign carry       = r_carry;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized bench for serial_adder_ctrl (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  sa_state_t    state_dbg;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .carry       (carry),
    .o_state_dbg (state_dbg)
  );

  // Scoreboard: {carry, sum} expected per launched operation
  logic [W:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: WIDTH-bit add with carry-out, or subtract with carry = no borrow
  function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int r;
    if (s) begin
      r = int'(x) - int'(y);
      return {(x >= y), W'(r)};
    end
    r = int'(x) + int'(y);
    return (W+1)'(r);
  endfunction

  // Driver: launch one operation, watch it to completion, check everything.
  // poke > 0 raises start with other operands for one cycle at that RUN cycle.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input int poke);
    int  lat;
    int  busy_n;
    int  done_n;
    logic finished;
    logic [W:0] e;
    lat = -1; busy_n = 0; done_n = 0; finished = 1'b0;
    exp_q.delete();
    exp_q.push_back(ref_op(ia, ib, isub));
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = isub;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = cyc;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          last_exp = e;
          check("sum", 32'(sum), 32'(e[W-1:0]));
          check("carry", 32'(carry), 32'(e[W]));
        end
      end
      // Operands wander after capture; they must not affect the result.
      start = (cyc == poke);
      a = (cyc == poke) ? W'(1) : W'($urandom);
      b = (cyc == poke) ? W'(1) : W'($urandom);
      sub = (cyc == poke) ? 1'b0 : 1'($urandom);
      if (cyc > 1 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("finished", 32'(finished), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_cycles", 32'(busy_n), 32'(W + 1));
    check("done_pulses", 32'(done_n), 32'd1);
    @(negedge clk);
    check("sum_held", 32'(sum), 32'(last_exp[W-1:0]));
    check("carry_held", 32'(carry), 32'(last_exp[W]));
  endtask

  initial begin
    int seen_done;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst = 1'b0;

    // Directed additions
    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'h0F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    // Start pulsed 3 cycles into RUN must be ignored
    run_op(8'h20, 8'h30, 1'b0, 3);
    check("poke_state_idle", 32'(state_dbg), 32'(IDLE));

    // Reset in RUN cycle 4
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h66; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    last_exp = '0;
    run_op(8'h03, 8'h04, 1'b0, 0);

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
`else
      run_op(W'($urandom), W'($urandom), 1'b0, 0);
`endif
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
